// File: rtl/acumulador_productos_if.sv
// Bus between a product accumulator and its environment.
//
// Purpose: bundles the product stream coming from the multiplier, the
// control inputs and the accumulated-result outputs into one interface.
//
// Signals:
//   resultado  signed product from the multiplier (2*NUM_BITS bits)
//   Fin        multiplier done level; each rising edge brings one new product
//   clear      synchronous abort/clear of the current block
//   tomado     consumer acknowledge of the delivered sum
//   suma       signed block sum (ACC_BITS bits), held between deliveries
//   valido     suma holds an unacknowledged result
//   n_prod     number of products accumulated in the current block
//   saturado   saturation occurred in the delivered block
//   perdido    a product was dropped while valido was high
//
// Modports: master = environment (drives products/controls),
//           slave  = accumulator (drives results).
//
// Handshake: a product is taken on the clock edge where Fin is seen rising.
// A result is offered while valido=1 and is consumed on the clock edge where
// tomado=1 and valido=1; suma is stable for as long as valido stays high.
interface acumulador_productos_if #(
  parameter int NUM_BITS = 4,
  parameter int GUARD    = 1
);
  localparam int ACC_BITS = 2*NUM_BITS + GUARD;

  logic [2*NUM_BITS-1:0] resultado;
  logic                  Fin;
  logic                  clear;
  logic                  tomado;
  logic [ACC_BITS-1:0]   suma;
  logic                  valido;
  logic [7:0]            n_prod;
  logic                  saturado;
  logic                  perdido;

  modport master (
    output resultado, Fin, clear, tomado,
    input  suma, valido, n_prod, saturado, perdido
  );

  modport slave (
    input  resultado, Fin, clear, tomado,
    output suma, valido, n_prod, saturado, perdido
  );
endinterface

// File: rtl/acumulador_productos.sv
// Saturating accumulator of blocks of NUM_PROD signed products.
//
// Purpose: each rising edge of Fin adds the current product to a saturating
// accumulator. When NUM_PROD products have been added, the block sum is
// delivered on suma/valido and held until acknowledged with tomado.
//
// Ports:
//   clk       system clock, rising-edge
//   rst_n     asynchronous active-low reset
//   bus       acumulador_productos_if.slave (products, controls, results)
//   estado_o  debug view of the FSM state (0 REPOSO, 1 ACUMULANDO, 2 ENTREGA)
module acumulador_productos #(
  parameter int NUM_BITS = 4,
  parameter int NUM_PROD = 4,
  parameter int GUARD    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  acumulador_productos_if.slave bus,
  output logic [1:0]            estado_o
);

  localparam int PB       = 2*NUM_BITS;
  localparam int ACC_BITS = PB + GUARD;
  localparam logic [ACC_BITS-1:0] ACC_MAX = {1'b0, {(ACC_BITS-1){1'b1}}};
  localparam logic [ACC_BITS-1:0] ACC_MIN = {1'b1, {(ACC_BITS-1){1'b0}}};
  localparam logic [7:0]          LAST_N  = 8'(NUM_PROD);

  typedef enum logic [1:0] {
    REPOSO     = 2'd0,
    ACUMULANDO = 2'd1,
    ENTREGA    = 2'd2
  } estado_t;

  estado_t             estado_q, estado_d;
  logic [ACC_BITS-1:0] acc_q, acc_d;
  logic [ACC_BITS-1:0] suma_q, suma_d;
  logic                valido_q, valido_d;
  logic [7:0]          n_prod_q, n_prod_d;
  logic                saturado_q, saturado_d;
  logic                perdido_q, perdido_d;
  logic                blk_sat_q, blk_sat_d;
  logic                fin_q;
  // arm_q stays low for the first edge after reset so a Fin level that was
  // already high when reset released is not mistaken for a new product.
  logic                arm_q;

  logic                evento;
  logic [ACC_BITS:0]   prod_ext;
  logic [ACC_BITS:0]   acc_ext;
  logic [ACC_BITS:0]   sum_wide;
  logic                ovf;
  logic [ACC_BITS-1:0] sum_sat;
  logic [7:0]          n_inc;

  assign evento = bus.Fin & ~fin_q & arm_q;

  // One extra bit of headroom: overflow shows up as the top two bits differing.
  assign prod_ext = {{(ACC_BITS+1-PB){bus.resultado[PB-1]}}, bus.resultado};
  assign acc_ext  = {acc_q[ACC_BITS-1], acc_q};
  assign sum_wide = acc_ext + prod_ext;
  assign ovf      = sum_wide[ACC_BITS] ^ sum_wide[ACC_BITS-1];
  assign sum_sat  = ovf ? (sum_wide[ACC_BITS] ? ACC_MIN : ACC_MAX)
                        : sum_wide[ACC_BITS-1:0];
  assign n_inc    = n_prod_q + 8'd1;

  always_comb begin
    estado_d   = estado_q;
    acc_d      = acc_q;
    suma_d     = suma_q;
    valido_d   = valido_q;
    n_prod_d   = n_prod_q;
    saturado_d = saturado_q;
    perdido_d  = perdido_q;
    blk_sat_d  = blk_sat_q;

    if (bus.clear) begin
      // Abort wins over everything; an event in this cycle is silently lost.
      estado_d   = REPOSO;
      acc_d      = '0;
      valido_d   = 1'b0;
      n_prod_d   = '0;
      saturado_d = 1'b0;
      perdido_d  = 1'b0;
      blk_sat_d  = 1'b0;
    end else begin
      unique case (estado_q)
        REPOSO, ACUMULANDO: begin
          if (evento) begin
            if (n_inc == LAST_N) begin
              // Final product: deliver the sum on this same edge.
              suma_d     = sum_sat;
              valido_d   = 1'b1;
              saturado_d = blk_sat_q | ovf;
              acc_d      = '0;
              n_prod_d   = '0;
              blk_sat_d  = 1'b0;
              estado_d   = ENTREGA;
            end else begin
              acc_d     = sum_sat;
              n_prod_d  = n_inc;
              blk_sat_d = blk_sat_q | ovf;
              estado_d  = ACUMULANDO;
            end
          end
        end
        ENTREGA: begin
          // acc is zero here, so sum_sat is just the incoming product.
          if (evento && bus.tomado) begin
            valido_d  = 1'b0;
            acc_d     = sum_sat;
            n_prod_d  = 8'd1;
            blk_sat_d = ovf;
            estado_d  = ACUMULANDO;
          end else if (evento) begin
            perdido_d = 1'b1;
          end else if (bus.tomado) begin
            valido_d = 1'b0;
            estado_d = REPOSO;
          end
        end
        default: estado_d = REPOSO;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q   <= REPOSO;
      acc_q      <= '0;
      suma_q     <= '0;
      valido_q   <= 1'b0;
      n_prod_q   <= '0;
      saturado_q <= 1'b0;
      perdido_q  <= 1'b0;
      blk_sat_q  <= 1'b0;
      fin_q      <= 1'b0;
      arm_q      <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      acc_q      <= acc_d;
      suma_q     <= suma_d;
      valido_q   <= valido_d;
      n_prod_q   <= n_prod_d;
      saturado_q <= saturado_d;
      perdido_q  <= perdido_d;
      blk_sat_q  <= blk_sat_d;
      fin_q      <= bus.Fin;
      arm_q      <= 1'b1;
    end
  end

  assign bus.suma     = suma_q;
  assign bus.valido   = valido_q;
  assign bus.n_prod   = n_prod_q;
  assign bus.saturado = saturado_q;
  assign bus.perdido  = perdido_q;
  assign estado_o     = estado_q;

endmodule
